// File: rtl/field_pkg.sv
// Shared playfield constants, colour-index type and palette lookup for the field renderer.
package field_pkg;

    localparam int unsigned ColorW       = 3;
    localparam int unsigned FieldCols    = 10;
    localparam int unsigned FieldRows    = 20;
    localparam int unsigned NumCells     = FieldCols * FieldRows;
    localparam int unsigned BorderPx     = 4;

    localparam int unsigned DefHActive   = 1024;
    localparam int unsigned DefVActive   = 768;
    localparam int unsigned DefFieldX0   = 352;
    localparam int unsigned DefFieldY0   = 64;
    localparam int unsigned DefCellShift = 5;

    typedef logic [ColorW-1:0] color_idx_t;
    typedef logic [23:0]       rgb_t;

    typedef enum logic [1:0] {
        RegionOutside,
        RegionBorder,
        RegionField
    } region_e;

    function automatic rgb_t palette(input color_idx_t idx);
        rgb_t rgb;
        case (idx)
            3'd0:    rgb = 24'h202020;
            3'd1:    rgb = 24'h00FFFF;
            3'd2:    rgb = 24'hFFFF00;
            3'd3:    rgb = 24'hA000F0;
            3'd4:    rgb = 24'h00FF00;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'hFFA500;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/field_cell_ram.sv
// Playfield cell store: 200 colour indices, one write port, combinational read-first lookup.
module field_cell_ram
    import field_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [7:0]        waddr_i,
    input  logic [ColorW-1:0] wdata_i,
    input  logic [7:0]        raddr_i,
    output logic [ColorW-1:0] rdata_o
);

    color_idx_t cells_q [NumCells];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumCells; i++) begin
                cells_q[i] <= '0;
            end
        end else if (we_i && (waddr_i < 8'(NumCells))) begin
            cells_q[waddr_i] <= wdata_i;
        end
    end

    // Read returns the pre-edge contents, so a same-cycle write is seen by the next lookup.
    assign rdata_o = (raddr_i < 8'(NumCells)) ? cells_q[raddr_i] : '0;

endmodule

// File: rtl/field_render.sv
// Raster pixel streamer: coordinate counter, cell lookup stage, colour register stage.
module field_render
    import field_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DefHActive,
    parameter int unsigned V_ACTIVE   = DefVActive,
    parameter int unsigned FIELD_X0   = DefFieldX0,
    parameter int unsigned FIELD_Y0   = DefFieldY0,
    parameter int unsigned CELL_SHIFT = DefCellShift
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CellWen,
    input  logic [7:0]        CellAddr,
    input  logic [ColorW-1:0] CellData,
    output logic [23:0]       Video,
    output logic              VideoValid,
    input  logic              VideoReady,
    output logic              FrameDone
);

    localparam int unsigned XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned FieldW = FieldCols << CELL_SHIFT;
    localparam int unsigned FieldH = FieldRows << CELL_SHIFT;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          last_px;

    logic          s1_valid_q;
    region_e       s1_region_q;
    color_idx_t    s1_cell_q;
    logic          s1_last_q;

    rgb_t          video_q, pix_d;
    logic          vid_valid_q;
    logic          vid_last_q;
    logic          frame_done_q;

    logic          advance;
    logic [31:0]   px, py, cell_col, cell_row;
    logic          in_field, in_ring;
    region_e       region;
    logic [7:0]    lookup_addr;
    color_idx_t    cell_rd;

    assign advance = VideoReady | ~vid_valid_q;
    assign last_px = (x_q == XW'(H_ACTIVE - 1)) && (y_q == YW'(V_ACTIVE - 1));

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == XW'(H_ACTIVE - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
        end
    end

    assign px = 32'(x_q);
    assign py = 32'(y_q);

    assign in_field = (px >= FIELD_X0) && (px < FIELD_X0 + FieldW) &&
                      (py >= FIELD_Y0) && (py < FIELD_Y0 + FieldH);
    // Offsets added on the pixel side so the left/top ring test cannot underflow.
    assign in_ring  = (px + BorderPx >= FIELD_X0) && (px < FIELD_X0 + FieldW + BorderPx) &&
                      (py + BorderPx >= FIELD_Y0) && (py < FIELD_Y0 + FieldH + BorderPx);

    assign cell_col    = (px - FIELD_X0) >> CELL_SHIFT;
    assign cell_row    = (py - FIELD_Y0) >> CELL_SHIFT;
    assign lookup_addr = in_field ? 8'(cell_row * FieldCols + cell_col) : 8'd0;

    always_comb begin
        region = RegionOutside;
        if (in_field) begin
            region = RegionField;
        end else if (in_ring) begin
            region = RegionBorder;
        end
    end

    field_cell_ram u_cell_ram (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .we_i    (CellWen),
        .waddr_i (CellAddr),
        .wdata_i (CellData),
        .raddr_i (lookup_addr),
        .rdata_o (cell_rd)
    );

    always_comb begin
        case (s1_region_q)
            RegionField:  pix_d = palette(s1_cell_q);
            RegionBorder: pix_d = 24'hFFFFFF;
            default:      pix_d = 24'h000000;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q          <= '0;
            y_q          <= '0;
            s1_valid_q   <= 1'b0;
            s1_region_q  <= RegionOutside;
            s1_cell_q    <= '0;
            s1_last_q    <= 1'b0;
            video_q      <= '0;
            vid_valid_q  <= 1'b0;
            vid_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= vid_valid_q & VideoReady & vid_last_q;
            if (advance) begin
                x_q         <= x_d;
                y_q         <= y_d;
                s1_valid_q  <= 1'b1;
                s1_region_q <= region;
                s1_cell_q   <= cell_rd;
                s1_last_q   <= last_px;
                vid_valid_q <= s1_valid_q;
                video_q     <= pix_d;
                vid_last_q  <= s1_valid_q & s1_last_q;
            end
        end
    end

    assign Video      = video_q;
    assign VideoValid = vid_valid_q;
    assign FrameDone  = frame_done_q;

endmodule

// File: tb/tb_field_render.sv
// Directed bench for field_render on a reduced raster (64x96, 4 px cells) to keep frames short.
module tb_field_render;

    localparam int H   = 64;
    localparam int V   = 96;
    localparam int FX0 = 12;
    localparam int FY0 = 8;
    localparam int CS  = 2;

    logic        Clock      = 1'b0;
    logic        Reset      = 1'b1;
    logic        CellWen    = 1'b0;
    logic [7:0]  CellAddr   = 8'd0;
    logic [2:0]  CellData   = 3'd0;
    logic        VideoReady = 1'b1;
    logic [23:0] Video;
    logic        VideoValid;
    logic        FrameDone;

    field_render #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIELD_X0   (FX0),
        .FIELD_Y0   (FY0),
        .CELL_SHIFT (CS)
    ) u_dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .CellWen    (CellWen),
        .CellAddr   (CellAddr),
        .CellData   (CellData),
        .Video      (Video),
        .VideoValid (VideoValid),
        .VideoReady (VideoReady),
        .FrameDone  (FrameDone)
    );

    initial forever #5 Clock = ~Clock;

    int          num_tests = 0;
    int          num_fail  = 0;
    logic [2:0]  mcell [200];
    logic [23:0] fb [H*V];
    bit          mon_chk = 1'b1;
    bit          rnd_on  = 1'b0;
    int          ex, ey, frames, xfers, frame_xfers, pix_err, stall_err, fd_err, stalls;
    logic [31:0] run_sum, frame_sum, sum_ref;
    bit          prev_stall, last_prev;
    logic [23:0] prev_vid;
    int          fr0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_tests++;
        if (got !== exp) begin
            num_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pal(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'h202020;
            3'd1:    return 24'h00FFFF;
            3'd2:    return 24'hFFFF00;
            3'd3:    return 24'hA000F0;
            3'd4:    return 24'h00FF00;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'hFFA500;
        endcase
    endfunction

    function automatic logic [23:0] exp_pixel(input int x, input int y);
        int fw = 10 << CS;
        int fh = 20 << CS;
        if (x >= FX0 && x < FX0 + fw && y >= FY0 && y < FY0 + fh)
            return pal(mcell[((y - FY0) >> CS) * 10 + ((x - FX0) >> CS)]);
        if (x >= FX0 - 4 && x < FX0 + fw + 4 && y >= FY0 - 4 && y < FY0 + fh + 4)
            return 24'hFFFFFF;
        return 24'h000000;
    endfunction

    function automatic int pidx(input int x, input int y);
        return y * H + x;
    endfunction

    // Ready is 1 unless the random-stall phase is active.
    initial forever begin
        @(posedge Clock);
        #1;
        VideoReady = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Transfer monitor: tracks raster position, frame buffer, checksum and handshake rules.
    initial forever begin
        @(negedge Clock);
        if (Reset) begin
            ex = 0; ey = 0; xfers = 0; run_sum = '0;
            prev_stall = 1'b0; last_prev = 1'b0;
        end else begin
            if (FrameDone !== last_prev) fd_err++;
            if (FrameDone === 1'b1) frames++;
            if (prev_stall && (VideoValid !== 1'b1 || Video !== prev_vid)) stall_err++;
            last_prev = 1'b0;
            if (VideoValid && !VideoReady) stalls++;
            if (VideoValid && VideoReady) begin
                fb[pidx(ex, ey)] = Video;
                if (mon_chk && Video !== exp_pixel(ex, ey)) pix_err++;
                run_sum = {run_sum[30:0], run_sum[31]} ^ {8'h00, Video};
                xfers++;
                if (ex == H - 1) begin
                    ex = 0;
                    if (ey == V - 1) begin
                        ey = 0;
                        last_prev = 1'b1;
                        frame_sum = run_sum;
                        run_sum = '0;
                        frame_xfers = xfers;
                        xfers = 0;
                    end else begin
                        ey++;
                    end
                end else begin
                    ex++;
                end
            end
            prev_stall = VideoValid && !VideoReady;
            prev_vid = Video;
        end
    end

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 40000) begin
            @(posedge Clock); #1; n++;
        end
        check_eq("wait_frames", 32'(frames), 32'(target));
    endtask

    task automatic wait_xy(input int x, input int y);
        int n = 0;
        while (!(ex == x && ey == y) && n < 20000) begin
            @(posedge Clock); #1; n++;
        end
        check_eq("wait_xy", 32'(ex == x && ey == y), 32'd1);
    endtask

    task automatic cell_write(input int addr, input int data);
        CellWen = 1'b1; CellAddr = 8'(addr); CellData = 3'(data);
        if (addr < 200) mcell[addr] = 3'(data);
        @(posedge Clock); #1;
        CellWen = 1'b0;
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input logic [23:0] exp);
        check_eq(tag, 32'(fb[pidx(x, y)]), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < 200; i++) mcell[i] = 3'd0;

        // Reset state and first-pixel latency.
        repeat (3) @(posedge Clock);
        #1;
        check_eq("rst_valid", 32'(VideoValid), 32'd0);
        check_eq("rst_video", 32'(Video), 32'd0);
        check_eq("rst_fdone", 32'(FrameDone), 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        check_eq("e1_valid", 32'(VideoValid), 32'd0);
        @(posedge Clock); #1;
        check_eq("e2_valid", 32'(VideoValid), 32'd1);
        check_eq("e2_pix00", 32'(Video), 32'd0);

        // Frame 1: empty field.
        wait_frames(1);
        check_eq("f1_xfers", 32'(frame_xfers), 32'(H * V));
        check_pix("f1_empty", FX0, FY0, 24'h202020);
        check_pix("f1_ring_tl", FX0 - 4, FY0, 24'hFFFFFF);
        check_pix("f1_out_l", FX0 - 5, FY0, 24'h000000);
        check_pix("f1_ring_br", FX0 + 43, FY0 + 83, 24'hFFFFFF);
        check_pix("f1_out_br", FX0 + 44, FY0 + 83, 24'h000000);

        // Writes near frame end, where only non-field pixels are in flight.
        wait_xy(0, V - 3);
        cell_write(0, 5);
        cell_write(200, 7);
        cell_write(199, 7);
        wait_frames(3);
        sum_ref = frame_sum;
        check_pix("c0_tl", FX0, FY0, 24'hFF0000);
        check_pix("c0_br", FX0 + 3, FY0 + 3, 24'hFF0000);
        check_pix("c1_tl", FX0 + 4, FY0, 24'h202020);
        check_pix("ring_c0", FX0 - 4, FY0, 24'hFFFFFF);
        check_pix("out_c0", FX0 - 5, FY0, 24'h000000);
        check_pix("c199_tl", FX0 + 36, FY0 + 76, 24'hFFA500);
        check_pix("c199_br", FX0 + 39, FY0 + 79, 24'hFFA500);
        check_eq("pix_err_f3", 32'(pix_err), 32'd0);

        // Random back-pressure for two frames.
        rnd_on = 1'b1;
        wait_frames(5);
        rnd_on = 1'b0;
        check_eq("rnd_sum", frame_sum, sum_ref);
        check_eq("rnd_xfers", 32'(frame_xfers), 32'(H * V));
        check_eq("rnd_stall", 32'(stall_err), 32'd0);
        check_eq("rnd_stalls_seen", 32'(stalls > 0), 32'd1);
        check_eq("rnd_pix_err", 32'(pix_err), 32'd0);

        // Mid-frame reset with a simultaneous write that must lose to reset.
        wait_xy(40, 50);
        mon_chk = 1'b0;
        fr0 = frames;
        Reset = 1'b1; CellWen = 1'b1; CellAddr = 8'd0; CellData = 3'd3;
        for (int i = 0; i < 200; i++) mcell[i] = 3'd0;
        @(posedge Clock); #1;
        check_eq("mid_rst_valid", 32'(VideoValid), 32'd0);
        check_eq("mid_rst_video", 32'(Video), 32'd0);
        check_eq("mid_rst_fdone", 32'(FrameDone), 32'd0);
        Reset = 1'b0; CellWen = 1'b0;
        @(posedge Clock); #1;
        check_eq("mid_e1_valid", 32'(VideoValid), 32'd0);
        @(posedge Clock); #1;
        check_eq("mid_e2_valid", 32'(VideoValid), 32'd1);
        check_eq("mid_e2_pix00", 32'(Video), 32'd0);
        check_eq("mid_no_fdone", 32'(frames), 32'(fr0));

        // Write cell 0 on the edge that registers the lookup of pixel (FX0,FY0).
        repeat (522) begin
            @(posedge Clock); #1;
        end
        CellWen = 1'b1; CellAddr = 8'd0; CellData = 3'd1;
        @(posedge Clock); #1;
        CellWen = 1'b0;
        wait_xy(FX0 + 2, FY0);
        mcell[0] = 3'd1;
        mon_chk = 1'b1;
        wait_frames(fr0 + 1);
        check_pix("rf_old", FX0, FY0, 24'h202020);
        check_pix("rf_new", FX0 + 1, FY0, 24'h00FFFF);
        check_pix("rf_row9", FX0, FY0 + 1, 24'h00FFFF);
        check_pix("cleared_c199", FX0 + 36, FY0 + 76, 24'h202020);
        check_eq("rst_frame_xfers", 32'(frame_xfers), 32'(H * V));
        check_eq("pix_err_final", 32'(pix_err), 32'd0);
        check_eq("fdone_err", 32'(fd_err), 32'd0);
        check_eq("stall_err_final", 32'(stall_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule

// File: doc/field_render.md
FIELD_RENDER -- requirements
Module: field_render

Interface
REQ-001 Parameter H_ACTIVE, 1024, active pixels per line.
REQ-002 Parameter V_ACTIVE, 768, active lines per frame.
REQ-003 Parameter FIELD_X0, 352, left pixel column of the playfield.
REQ-004 Parameter FIELD_Y0, 64, top pixel line of the playfield.
REQ-005 Parameter CELL_SHIFT, 5, log2 of the cell edge in pixels (32 px cells).
REQ-006 Port Clock  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-007 Port Reset  in  1  synchronous, active-high reset.
REQ-008 Port CellWen  in  1  cell write strobe.
REQ-009 Port CellAddr  in  8  cell index row*10+col, 0..199.
REQ-010 Port CellData  in  3  cell colour index; 0 means empty.
REQ-011 Port Video  out  24  pixel {R[7:0],G[7:0],B[7:0]}.
REQ-012 Port VideoValid  out  1  Video holds a valid pixel.
REQ-013 Port VideoReady  in  1  sink accepts the pixel this cycle.
REQ-014 Port FrameDone  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 The block SHALL stream H_ACTIVE*V_ACTIVE pixels per frame in raster order (x fastest) and SHALL restart at (0,0) with no gap.
REQ-016 A pixel transfer SHALL occur on a cycle where VideoValid=1 and VideoReady=1.
REQ-017 While VideoValid=1 and VideoReady=0, Video SHALL stay stable and VideoValid SHALL stay 1.
REQ-018 The pipeline SHALL be 2 stages (coordinate/cell lookup, colour register); all stages SHALL advance when VideoReady=1 or VideoValid=0, and none otherwise.
REQ-019 After Reset deasserts, VideoValid SHALL first be 1 on the 2nd rising edge, carrying pixel (0,0).
REQ-020 The playfield is 10 cols x 20 rows; field pixel (x,y) lies within x in [FIELD_X0, FIELD_X0+320), y in [FIELD_Y0, FIELD_Y0+640).
REQ-021 A field pixel SHALL show the palette colour of cell ((y-FIELD_Y0)>>CELL_SHIFT)*10+((x-FIELD_X0)>>CELL_SHIFT).
REQ-022 Palette: 0=202020, 1=00FFFF, 2=FFFF00, 3=A000F0, 4=00FF00, 5=FF0000, 6=0000FF, 7=FFA500.
REQ-023 Pixels within 4 px outside the field rectangle (border ring) SHALL be FFFFFF; all other pixels SHALL be 000000.
REQ-024 Cell storage SHALL be 200 x 3-bit registers; a write with CellWen=1 and CellAddr<=199 SHALL update the cell on that edge.
REQ-025 Writes with CellAddr>=200 SHALL be ignored.
REQ-026 A write and a lookup of the same cell in one cycle SHALL return the old value (read-first); the new value SHALL be visible from the next lookup.
REQ-027 Writes SHALL be accepted every cycle regardless of VideoReady stalls.
REQ-028 FrameDone SHALL pulse high for exactly one cycle, on the cycle after pixel (H_ACTIVE-1,V_ACTIVE-1) is transferred.
REQ-029 x SHALL wrap from H_ACTIVE-1 to 0 and increment y; y SHALL wrap from V_ACTIVE-1 to 0.

Reset
REQ-030 On Reset=1: VideoValid=0, Video=000000, FrameDone=0, x=y=0, all cells=0, pipeline stage valids=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame without a FrameDone pulse; the next frame SHALL start at (0,0) per REQ-019.
REQ-032 Reset SHALL take priority over a simultaneous CellWen.

Structure
REQ-033 Palette constants, field geometry defaults and the 3-bit colour-index width SHALL live in a shared package field_pkg.
REQ-034 The cell register array with write port and read-first lookup SHALL be one sub-module field_cell_ram; all else SHALL be in field_render.

Verification
REQ-035 Reset release, VideoReady=1 constant -> VideoValid=1 on 2nd edge, Video=000000 for (0,0); FrameDone after 786432 transfers.
REQ-036 Write cell 0 = 5, ready constant -> pixels (352..383, 64..95) = FF0000; pixel (348,64) = FFFFFF; (347,64) = 000000.
REQ-037 Toggle VideoReady pseudo-randomly at 50% -> no pixel lost/duplicated; Video stable during every stall; frame checksum equals the ready-constant run.
REQ-038 Write CellAddr=200 data 7, then CellAddr=199 data 7 -> no change anywhere for 200; pixels (640..671, 672..703) = FFA500.
REQ-039 Write cell 0 = 1 on the same cycle pixel (352,64) is looked up -> that pixel 202020, pixel (353,64) 00FFFF.
REQ-040 Assert Reset at pixel (500,300) for 1 cycle -> no FrameDone, VideoValid=0, cells cleared, stream restarts at (0,0) on 2nd edge after release.
